// File: rtl/panic_lat_stats_pkg.sv
// panic_lat_stats_pkg: shared widths, record layout and encodings for the latency statistics engine
`ifndef PANIC_DESC_TS_SIZE
`define PANIC_DESC_TS_SIZE 32
`endif
package panic_lat_stats_pkg;
  localparam int DESC_TS_W = `PANIC_DESC_TS_SIZE;
  localparam int STAT_SUM_W = 64;
  localparam int STAT_CNT_W = 32;
  localparam int WIN_FREE_RUN = 0;
  localparam bit MIN_RST_BIT = 1'b1;
endpackage

// File: rtl/panic_lat_stats_rec.sv
// panic_lat_stats_rec: one class record with saturating accumulate, min/max tracking and snapshot copy
module panic_lat_stats_rec
  import panic_lat_stats_pkg::*;
#(
  parameter int TS_WIDTH = DESC_TS_W,
  parameter int SUM_WIDTH = STAT_SUM_W,
  parameter int CNT_WIDTH = STAT_CNT_W,
  parameter int WINDOW = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 acc_i,
  input  logic                 snap_i,
  input  logic [TS_WIDTH-1:0]  lat_i,
  output logic                 win_o,
  output logic [SUM_WIDTH-1:0] sum_o,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic [TS_WIDTH-1:0]  min_o,
  output logic [TS_WIDTH-1:0]  max_o
);
  localparam int AW = (SUM_WIDTH > TS_WIDTH ? SUM_WIDTH : TS_WIDTH) + 1;
  localparam logic [AW-1:0] SUM_MAX = AW'({SUM_WIDTH{1'b1}});
  localparam logic [CNT_WIDTH-1:0] WIN_CNT = CNT_WIDTH'(WINDOW);
  localparam logic [TS_WIDTH-1:0] MIN_RST = {TS_WIDTH{MIN_RST_BIT}};
  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [TS_WIDTH-1:0] min_q, min_d, max_q, max_d;
  logic [AW-1:0] sum_full;
  logic cp;
  // fold the stage-2 sample into the live values; a copy uses these folded values
  always_comb begin
    sum_full = AW'(sum_q) + AW'(lat_i);
    sum_d = !acc_i ? sum_q : sum_full > SUM_MAX ? '1 : sum_full[SUM_WIDTH-1:0];
    cnt_d = acc_i && cnt_q != '1 ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    min_d = acc_i && lat_i < min_q ? lat_i : min_q;
    max_d = acc_i && lat_i > max_q ? lat_i : max_q;
    win_o = WINDOW != WIN_FREE_RUN && acc_i && cnt_d == WIN_CNT;
    cp = win_o || snap_i;
  end
  // live record restarts whenever it is copied to the snapshot
  always_ff @(posedge clk)
    if (rst || clr_i) begin
      sum_q <= '0;
      cnt_q <= '0;
      min_q <= MIN_RST;
      max_q <= '0;
      sum_o <= '0;
      cnt_o <= '0;
      min_o <= MIN_RST;
      max_o <= '0;
    end else begin
      sum_q <= cp ? '0 : sum_d;
      cnt_q <= cp ? '0 : cnt_d;
      min_q <= cp ? MIN_RST : min_d;
      max_q <= cp ? '0 : max_d;
      sum_o <= cp ? sum_d : sum_o;
      cnt_o <= cp ? cnt_d : cnt_o;
      min_o <= cp ? min_d : min_o;
      max_o <= cp ? max_d : max_o;
    end
endmodule

// File: rtl/panic_lat_stats.sv
// panic_lat_stats: per-class latency sum/count/min/max with windowed snapshots and a host read port
module panic_lat_stats
  import panic_lat_stats_pkg::*;
#(
  parameter int TS_WIDTH = DESC_TS_W,
  parameter int NUM_CLASS = 8,
  parameter int CLASS_WIDTH = 5,
  parameter int SUM_WIDTH = STAT_SUM_W,
  parameter int CNT_WIDTH = STAT_CNT_W,
  parameter int WINDOW = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  input  logic [TS_WIDTH-1:0]    s_ts,
  input  logic [TS_WIDTH-1:0]    timestamp,
  input  logic [CLASS_WIDTH-1:0] s_class,
  input  logic                   clear,
  input  logic                   snap_req,
  output logic                   win_valid,
  output logic [CLASS_WIDTH-1:0] win_class,
  input  logic                   rd_req,
  input  logic [CLASS_WIDTH-1:0] rd_class,
  output logic                   rd_valid,
  output logic [SUM_WIDTH-1:0]   rd_sum,
  output logic [CNT_WIDTH-1:0]   rd_cnt,
  output logic [TS_WIDTH-1:0]    rd_min,
  output logic [TS_WIDTH-1:0]    rd_max,
  output logic [31:0]            drop_cnt
);
  localparam logic [TS_WIDTH-1:0] MIN_RST = {TS_WIDTH{MIN_RST_BIT}};
  logic s_in_range;
  logic v_q;
  logic [TS_WIDTH-1:0] lat_q;
  logic [CLASS_WIDTH-1:0] cls_q, win_cls;
  logic [NUM_CLASS-1:0] acc, win;
  logic [SUM_WIDTH-1:0] snap_sum [NUM_CLASS];
  logic [CNT_WIDTH-1:0] snap_cnt [NUM_CLASS];
  logic [TS_WIDTH-1:0] snap_min [NUM_CLASS];
  logic [TS_WIDTH-1:0] snap_max [NUM_CLASS];
  logic [SUM_WIDTH-1:0] rd_sum_d;
  logic [CNT_WIDTH-1:0] rd_cnt_d;
  logic [TS_WIDTH-1:0] rd_min_d, rd_max_d;
  assign s_in_range = int'(s_class) < NUM_CLASS;
  // stage 1: modular latency so timestamp wrap needs no special case
  always_ff @(posedge clk)
    if (rst || clear) begin
      v_q <= 1'b0;
      lat_q <= '0;
      cls_q <= '0;
    end else begin
      v_q <= s_valid && s_in_range;
      lat_q <= timestamp - s_ts;
      cls_q <= s_class;
    end
  // saturating count of samples whose class has no record
  always_ff @(posedge clk)
    if (rst || clear) drop_cnt <= '0;
    else drop_cnt <= s_valid && !s_in_range && drop_cnt != '1 ? drop_cnt + 32'd1 : drop_cnt;
  for (genvar g = 0; g < NUM_CLASS; g++) begin : g_rec
    assign acc[g] = v_q && cls_q == CLASS_WIDTH'(g);
    panic_lat_stats_rec #(
      .TS_WIDTH(TS_WIDTH), .SUM_WIDTH(SUM_WIDTH), .CNT_WIDTH(CNT_WIDTH), .WINDOW(WINDOW)
    ) u_rec (
      .clk(clk), .rst(rst), .clr_i(clear), .acc_i(acc[g]), .snap_i(snap_req), .lat_i(lat_q),
      .win_o(win[g]), .sum_o(snap_sum[g]), .cnt_o(snap_cnt[g]), .min_o(snap_min[g]), .max_o(snap_max[g])
    );
  end
  // at most one class completes per cycle; unknown read classes fall through to empty values
  always_comb begin
    win_cls = '0;
    rd_sum_d = '0;
    rd_cnt_d = '0;
    rd_min_d = MIN_RST;
    rd_max_d = '0;
    for (int i = 0; i < NUM_CLASS; i++) begin
      win_cls = win[i] ? CLASS_WIDTH'(i) : win_cls;
      rd_sum_d = rd_class == CLASS_WIDTH'(i) ? snap_sum[i] : rd_sum_d;
      rd_cnt_d = rd_class == CLASS_WIDTH'(i) ? snap_cnt[i] : rd_cnt_d;
      rd_min_d = rd_class == CLASS_WIDTH'(i) ? snap_min[i] : rd_min_d;
      rd_max_d = rd_class == CLASS_WIDTH'(i) ? snap_max[i] : rd_max_d;
    end
  end
  // window-done pulse lands with the snapshot write
  always_ff @(posedge clk)
    if (rst || clear) begin
      win_valid <= 1'b0;
      win_class <= '0;
    end else begin
      win_valid <= |win;
      win_class <= win_cls;
    end
  // registered read sees the snapshot as it was before this edge
  always_ff @(posedge clk)
    if (rst) begin
      rd_valid <= 1'b0;
      rd_sum <= '0;
      rd_cnt <= '0;
      rd_min <= MIN_RST;
      rd_max <= '0;
    end else begin
      rd_valid <= rd_req;
      rd_sum <= rd_req ? rd_sum_d : rd_sum;
      rd_cnt <= rd_req ? rd_cnt_d : rd_cnt;
      rd_min <= rd_req ? rd_min_d : rd_min;
      rd_max <= rd_req ? rd_max_d : rd_max;
    end
endmodule

// File: tb/tb_panic_lat_stats.sv
// tb_panic_lat_stats: scoreboard bench over three configurations of the latency statistics engine
module tb_panic_lat_stats;
  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, clear = 1'b0, snap_req = 1'b0, rd_req = 1'b0;
  logic [31:0] s_ts = '0, timestamp = '0;
  logic [4:0] s_class = '0, rd_class = '0;
  logic wv [3];
  logic rv [3];
  logic [4:0] wc [3];
  logic [31:0] rc [3];
  logic [31:0] rmn [3];
  logic [31:0] rmx [3];
  logic [31:0] dc [3];
  logic [63:0] rs_a, rs_c, rs_sel;
  logic [7:0] rs_b;
  int sel = 0, win_sz = 4, cyc = 0, n_chk = 0, n_pass = 0;
  int mcnt [8];
  typedef struct { int cyc; logic [4:0] cls; } win_exp_t;
  typedef struct { int cyc; logic [63:0] sum; logic [31:0] cnt; logic [31:0] mn; logic [31:0] mx; } rd_exp_t;
  win_exp_t wq [$];
  rd_exp_t rq [$];
  win_exp_t we;
  rd_exp_t re;

  panic_lat_stats #(.WINDOW(4)) dut_a (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ts(s_ts), .timestamp(timestamp), .s_class(s_class),
    .clear(clear), .snap_req(snap_req), .win_valid(wv[0]), .win_class(wc[0]), .rd_req(rd_req),
    .rd_class(rd_class), .rd_valid(rv[0]), .rd_sum(rs_a), .rd_cnt(rc[0]), .rd_min(rmn[0]),
    .rd_max(rmx[0]), .drop_cnt(dc[0]));
  panic_lat_stats #(.WINDOW(0), .SUM_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ts(s_ts), .timestamp(timestamp), .s_class(s_class),
    .clear(clear), .snap_req(snap_req), .win_valid(wv[1]), .win_class(wc[1]), .rd_req(rd_req),
    .rd_class(rd_class), .rd_valid(rv[1]), .rd_sum(rs_b), .rd_cnt(rc[1]), .rd_min(rmn[1]),
    .rd_max(rmx[1]), .drop_cnt(dc[1]));
  panic_lat_stats #(.WINDOW(128)) dut_c (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ts(s_ts), .timestamp(timestamp), .s_class(s_class),
    .clear(clear), .snap_req(snap_req), .win_valid(wv[2]), .win_class(wc[2]), .rd_req(rd_req),
    .rd_class(rd_class), .rd_valid(rv[2]), .rd_sum(rs_c), .rd_cnt(rc[2]), .rd_min(rmn[2]),
    .rd_max(rmx[2]), .drop_cnt(dc[2]));

  assign rs_sel = sel == 0 ? rs_a : sel == 1 ? {56'b0, rs_b} : rs_c;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) if (!rst) begin
    if (wv[sel]) begin
      if (wq.size() == 0) chk("win_unexpected", 64'(wv[sel]), 0);
      else begin
        we = wq.pop_front();
        chk("win_cycle", 64'(cyc), 64'(we.cyc));
        chk("win_class", 64'(wc[sel]), 64'(we.cls));
      end
    end
    if (rv[sel]) begin
      if (rq.size() == 0) chk("rd_unexpected", 64'(rv[sel]), 0);
      else begin
        re = rq.pop_front();
        chk("rd_cycle", 64'(cyc), 64'(re.cyc));
        chk("rd_sum", rs_sel, re.sum);
        chk("rd_cnt", 64'(rc[sel]), 64'(re.cnt));
        chk("rd_min", 64'(rmn[sel]), 64'(re.mn));
        chk("rd_max", 64'(rmx[sel]), 64'(re.mx));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 8; i++) mcnt[i] = 0;
  endtask

  task automatic use_dut(int s);
    sel = s;
    win_sz = s == 0 ? 4 : s == 1 ? 0 : 128;
    reset_model();
  endtask

  task automatic sample_ts(int c, logic [31:0] now, logic [31:0] ts);
    s_valid = 1'b1;
    s_class = 5'(c);
    timestamp = now;
    s_ts = ts;
    if (c < 8) begin
      mcnt[c]++;
      if (win_sz != 0 && mcnt[c] == win_sz) begin
        wq.push_back('{cyc + 2, 5'(c)});
        mcnt[c] = 0;
      end
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic sample(int c, int lat);
    logic [31:0] now = $urandom;
    sample_ts(c, now, now - 32'(lat));
  endtask

  task automatic rd(int c, logic [63:0] sum, logic [31:0] cnt, logic [31:0] mn, logic [31:0] mx);
    rd_req = 1'b1;
    rd_class = 5'(c);
    rq.push_back('{cyc + 1, sum, cnt, mn, mx});
    tick();
    rd_req = 1'b0;
  endtask

  task automatic rd_empty(int c);
    rd(c, 0, 0, 32'hFFFF_FFFF, 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    reset_model();
  endtask

  task automatic do_snap();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    reset_model();
  endtask

  task automatic settle(string tag);
    repeat (3) tick();
    chk({tag, "_win_pending"}, 64'(wq.size()), 0);
    chk({tag, "_rd_pending"}, 64'(rq.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, n_pass=%0d n_chk=%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    reset_model();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_win_valid", 64'(wv[0]), 0);
    chk("rst_rd_valid", 64'(rv[0]), 0);
    chk("rst_rd_sum", rs_a, 0);
    chk("rst_rd_cnt", 64'(rc[0]), 0);
    chk("rst_rd_min", 64'(rmn[0]), 64'hFFFF_FFFF);
    chk("rst_rd_max", 64'(rmx[0]), 0);
    chk("rst_drop_cnt", 64'(dc[0]), 0);
    tick();
    use_dut(0);
    rd_empty(2);
    sample(2, 10);
    sample(2, 20);
    sample(2, 5);
    sample(2, 40);
    tick();
    tick();
    rd(2, 75, 4, 5, 40);
    repeat (4) sample(2, 3);
    tick();
    tick();
    rd(2, 12, 4, 3, 3);
    settle("basic");
    repeat (4) sample_ts(5, 32'h0000_0010, 32'hFFFF_FFF0);
    tick();
    tick();
    rd(5, 128, 4, 32, 32);
    settle("wrap");
    do_clear();
    repeat (3) sample(9, 11);
    tick();
    chk("drop_cnt", 64'(dc[0]), 3);
    rd_empty(1);
    rd_empty(9);
    settle("range");
    use_dut(2);
    do_clear();
    for (int i = 0; i < 256; i++) sample(i % 2, 7);
    tick();
    tick();
    rd(0, 896, 128, 7, 7);
    rd(1, 896, 128, 7, 7);
    settle("b2b");
    use_dut(1);
    do_clear();
    sample(4, 200);
    sample(4, 100);
    repeat (3) tick();
    do_snap();
    tick();
    rd(4, 255, 2, 100, 200);
    settle("sat");
    sample(3, 1);
    sample(3, 2);
    sample(3, 3);
    do_snap();
    tick();
    rd(3, 6, 3, 1, 3);
    do_snap();
    tick();
    rd_empty(3);
    settle("fold");
    sample(6, 50);
    tick();
    tick();
    do_snap();
    tick();
    rd(6, 50, 1, 50, 50);
    sample(20, 1);
    chk("drop_before_clear", 64'(dc[1]), 1);
    sample(6, 77);
    do_clear();
    chk("drop_after_clear", 64'(dc[1]), 0);
    tick();
    do_snap();
    tick();
    rd_empty(6);
    rd_empty(3);
    settle("clear");
    use_dut(2);
    do_clear();
    for (int i = 0; i < 100; i++) sample(0, 7);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    reset_model();
    tick();
    rd_empty(0);
    for (int i = 0; i < 128; i++) sample(0, 7);
    tick();
    tick();
    rd(0, 896, 128, 7, 7);
    settle("midrst");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
